// File: rtl/fetch_if.sv
// Fetch-stage bus: control inputs, instruction-memory port and IF/ID outputs.
// The fetch stage takes the master side because it drives the memory address
// and the IF/ID register. The environment (pipeline control and memory) takes
// the slave side.
interface fetch_if #(
    parameter int D = 6,
    parameter int W = 32
);
    logic         start;
    logic         stall;
    logic         branch_taken;
    logic [D-1:0] branch_target;
    logic [D-1:0] imem_address;
    logic [W-1:0] imem_read;
    logic [W-1:0] instr;
    logic [D-1:0] instr_pc;
    logic         instr_valid;
    logic         halted;

    modport master (
        input  start, stall, branch_taken, branch_target, imem_read,
        output imem_address, instr, instr_pc, instr_valid, halted
    );

    modport slave (
        output start, stall, branch_taken, branch_target, imem_read,
        input  imem_address, instr, instr_pc, instr_valid, halted
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage. It holds the PC and drives the word address to an
// asynchronous-read instruction memory. It registers the returned word into
// IF/ID. It supports stall, branch redirect with a single bubble, a start
// handshake and a halt state.
module fetch_stage #(
    parameter int          D         = 6,
    parameter int          W         = 32,
    parameter logic [W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [D-1:0] pc_q, pc_d;
    logic [W-1:0] instr_q, instr_d;
    logic [D-1:0] instr_pc_q, instr_pc_d;
    logic         instr_valid_q, instr_valid_d;
    logic         halted_q, halted_d;

    // The memory is read combinationally, so the PC goes straight out.
    assign bus.imem_address = pc_q;
    assign bus.instr        = instr_q;
    assign bus.instr_pc     = instr_pc_q;
    assign bus.instr_valid  = instr_valid_q;
    assign bus.halted       = halted_q;

    // Next-state logic. Branch beats stall, which beats a normal fetch. By
    // default every register holds its value, which is how a stall behaves.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        case (state_q)
            IDLE: begin
                // The stage waits for start here. Stall and branch are ignored.
                pc_d          = '0;
                instr_d       = '0;
                instr_pc_d    = '0;
                instr_valid_d = 1'b0;
                if (bus.start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.branch_taken) begin
                    pc_d          = bus.branch_target;
                    instr_d       = '0;
                    instr_pc_d    = '0;
                    instr_valid_d = 1'b0;
                end else if (!bus.stall) begin
                    instr_d       = bus.imem_read;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    // A halt word is still passed to decode. The PC then
                    // freezes on it so that imem_address points at the halt.
                    if (bus.imem_read == HALT_WORD) begin
                        state_d = HALT;
                    end else begin
                        pc_d = pc_q + D'(1);
                    end
                end
            end
            HALT: begin
                if (bus.branch_taken) begin
                    // The halt was fetched on a path that is being squashed,
                    // so fetching resumes at the branch target.
                    pc_d          = bus.branch_target;
                    instr_d       = '0;
                    instr_pc_d    = '0;
                    instr_valid_d = 1'b0;
                    state_d       = RUN;
                end else if (!bus.stall) begin
                    instr_d       = '0;
                    instr_pc_d    = '0;
                    instr_valid_d = 1'b0;
                end
            end
            default: begin
                state_d       = IDLE;
                pc_d          = '0;
                instr_d       = '0;
                instr_pc_d    = '0;
                instr_valid_d = 1'b0;
            end
        endcase

        halted_d = (state_d == HALT);
    end

    // State and output registers. Reset is asynchronous and returns the
    // stage to IDLE with a bubble in IF/ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. It runs directed scenarios and a
// randomized run against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;
    localparam int          D         = 6;
    localparam int          W         = 32;
    localparam int          DEPTH     = 1 << D;
    localparam logic [W-1:0] HALT_WORD = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fetch_if #(.D(D), .W(W)) bus ();

    fetch_stage #(.D(D), .W(W), .HALT_WORD(HALT_WORD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem [DEPTH];
    assign bus.imem_read = mem[bus.imem_address];

    // Reference model: program counter, whether the stage is running or
    // halted, and what decode should currently see.
    int           m_pc;
    bit           m_run, m_halt;
    logic [W-1:0] e_instr;
    int           e_ipc;
    bit           e_valid;

    int compared   = 0;
    int mismatched = 0;

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        w = $urandom;
        if (w == HALT_WORD) w = 32'h1234_5678;
        return w;
    endfunction

    function automatic void model_reset();
        m_pc = 0; m_run = 0; m_halt = 0;
        e_instr = '0; e_ipc = 0; e_valid = 0;
    endfunction

    function automatic void model_bubble();
        e_instr = '0; e_ipc = 0; e_valid = 0;
    endfunction

    // Applies one rising edge to the model, using the inputs as they stand.
    function automatic void model_edge();
        logic [W-1:0] w;
        if (!m_run && !m_halt) begin
            if (bus.start) m_run = 1;
        end else if (bus.branch_taken) begin
            m_pc = int'(bus.branch_target);
            model_bubble();
            m_run = 1; m_halt = 0;
        end else if (bus.stall) begin
            // everything holds
        end else if (m_halt) begin
            model_bubble();
        end else begin
            w = mem[m_pc];
            e_instr = w; e_ipc = m_pc; e_valid = 1;
            if (w == HALT_WORD) begin
                m_run = 0; m_halt = 1;
            end else begin
                m_pc = (m_pc + 1) % DEPTH;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".imem_address"}, W'(bus.imem_address), W'(m_pc));
        chk({ctx, ".instr"},        bus.instr,             e_instr);
        chk({ctx, ".instr_pc"},     W'(bus.instr_pc),      W'(e_ipc));
        chk({ctx, ".instr_valid"},  W'(bus.instr_valid),   W'(e_valid));
        chk({ctx, ".halted"},       W'(bus.halted),        W'(m_halt));
        $display("[%0t] %s pc=%0d instr=%h ipc=%0d v=%0b halted=%0b", $time, ctx,
                 bus.imem_address, bus.instr, bus.instr_pc, bus.instr_valid, bus.halted);
    endtask

    // One clock edge. The model advances on the edge, outputs are checked
    // 1 time unit later, and the caller then drives the next inputs.
    task automatic step(input string ctx);
        @(posedge clk);
        model_edge();
        #1;
        check_all(ctx);
    endtask

    task automatic drive(input bit s, input bit st, input bit br, input int tgt);
        bus.start = s; bus.stall = st; bus.branch_taken = br;
        bus.branch_target = D'(tgt);
    endtask

    task automatic async_reset(input string ctx);
        @(posedge clk);
        model_edge();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(ctx);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = rand_word();
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        drive(0, 0, 0, 0);
        model_reset();

        // Reset state
        #2;
        check_all("reset");
        #5 rst_n = 1'b1;

        // IDLE ignores stall and branch
        drive(0, 1, 1, 9);
        step("idle_ignore");
        drive(0, 0, 1, 17);
        step("idle_ignore2");

        // Start, then the first words in sequence
        drive(1, 0, 0, 0);
        step("start");
        drive(0, 0, 0, 0);
        step("fetch0");
        chk("seq0", bus.instr, 32'h11);
        step("fetch1");
        chk("seq1", bus.instr, 32'h22);

        // Three-cycle stall while 0x22 is in IF/ID
        drive(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step("stall");
        chk("stall_addr", W'(bus.imem_address), 32'd2);
        drive(0, 0, 0, 0);
        step("unstall");
        chk("after_stall", bus.instr, 32'h33);
        step("fetch3");
        step("fetch4");
        chk("pc5", W'(bus.imem_address), 32'd5);

        // Branch from pc=5 to 0x20, then again with stall asserted
        drive(0, 0, 1, 'h20);
        step("branch");
        drive(0, 0, 0, 0);
        step("branch_tgt");
        chk("branch_ipc", W'(bus.instr_pc), 32'h20);
        drive(0, 1, 1, 'h20);
        step("branch_stall");
        drive(0, 0, 0, 0);
        step("branch_stall_tgt");

        // Wrap from 0x3F to 0
        drive(0, 0, 1, 'h3F);
        step("wrap_br");
        drive(0, 0, 0, 0);
        step("wrap_3f");
        step("wrap_00");
        chk("wrap_ipc", W'(bus.instr_pc), 32'h00);

        // Halt at address 4, then stall during HALT, bubbles, and a squash
        mem[4] = HALT_WORD;
        drive(0, 0, 1, 0);
        step("halt_br0");
        drive(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("to_halt");
        chk("halt_word", bus.instr, HALT_WORD);
        chk("halt_flag", W'(bus.halted), 32'd1);
        drive(0, 1, 0, 0);
        step("halt_stall");
        drive(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("halt_bubble");
        chk("halt_addr", W'(bus.imem_address), 32'd4);
        drive(0, 0, 1, 'h10);
        step("halt_squash");
        drive(0, 0, 0, 0);
        step("after_squash");
        chk("squash_ipc", W'(bus.instr_pc), 32'h10);

        // Randomized run with a few halt words scattered through memory
        for (int i = 0; i < 3; i++) mem[$urandom_range(DEPTH - 1, 8)] = HALT_WORD;
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(9, 0) == 0, $urandom_range(3, 0) == 0,
                  $urandom_range(9, 0) == 0, int'($urandom_range(DEPTH - 1, 0)));
            step("rand");
        end

        // Asynchronous reset in the middle of activity, then restart
        drive(0, 0, 0, 0);
        async_reset("mid_reset");
        drive(1, 0, 0, 0);
        step("restart");
        drive(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("restart_run");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage: holds the program counter, drives the word address into the asynchronous-read instruction memory, and registers the returned word into the IF/ID pipeline register consumed by decode. Supports pipeline stalls, taken-branch redirection with bubble insertion, a start handshake after reset, and a halt state entered when a configurable halt word is fetched.

## Interface
Parameters:
- D, 6, PC/address width; instruction memory holds 2^D words, word-addressed.
- W, 32, instruction width in bits.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch (W bits).

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  leaves IDLE; sampled only in IDLE.
- stall  in  1  hold PC and IF/ID register this cycle.
- branch_taken  in  1  redirect request from a later stage.
- branch_target  in  D  word address to redirect to.
- imem_address  out  D  address to instruction memory; combinationally equal to pc.
- imem_read  in  W  instruction word returned combinationally by memory.
- instr  out  W  IF/ID instruction.
- instr_pc  out  D  word address that instr was fetched from.
- instr_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- halted  out  1  1 while in HALT.

## Operation
- Registers: pc[D-1:0], instr, instr_pc, instr_valid, state in {IDLE, RUN, HALT}.
- Bubble = instr 0, instr_pc 0, instr_valid 0.
- IDLE: pc held at 0, IF/ID bubble; stall and branch_taken ignored; start=1 -> RUN (no fetch issued that edge).
- RUN, priority branch_taken > stall > normal:
  - branch_taken: pc <= branch_target; IF/ID <= bubble; stay RUN.
  - stall: pc, IF/ID, state all hold.
  - normal: instr <= imem_read; instr_pc <= pc; instr_valid <= 1; pc <= pc+1 mod 2^D (2^D-1 wraps to 0). If imem_read == HALT_WORD: the halt word is still issued valid, pc is NOT incremented, state -> HALT.
- HALT: pc holds; halted=1.
  - branch_taken: pc <= branch_target; IF/ID <= bubble; state -> RUN (halt was on a squashed path).
  - stall: IF/ID holds (halt word stays visible to decode).
  - otherwise: IF/ID <= bubble.
  - start ignored.
- Reset (any time, including mid-RUN/HALT): asynchronously pc=0, IF/ID bubble, state IDLE, halted 0.

## Timing
- imem_address follows pc with zero cycles of logic delay; memory read is combinational, so fetch of address A completes in the cycle pc=A.
- Latency: pc=A at cycle n, not stalled, no branch -> instr=mem[A], instr_pc=A, instr_valid=1 after edge n.
- Start: start=1 sampled at edge k -> RUN; edge k+1 produces mem[0] on instr.
- Branch: branch_taken at edge n -> bubble after edge n, mem[target] after edge n+1 (one-cycle penalty). branch_taken with stall=1 in the same cycle: branch wins.
- Stall: outputs and pc unchanged across every stalled edge; throughput one instruction per unstalled cycle.
- halted asserts on the edge that registers HALT_WORD and deasserts on the edge that takes a branch in HALT.
- All outputs except imem_address are registered.

## Test plan
- Reset/start: rst_n low mid-RUN -> pc=0, instr=0, instr_valid=0, halted=0 immediately; start pulse then mem[0..3] = 0x11,0x22,0x33,0x44 appear on consecutive cycles with instr_pc 0,1,2,3.
- Stall: assert stall 3 cycles while instr=0x22 -> instr, instr_pc=1, imem_address=2 held for 3 edges; release -> 0x33 next.
- Branch: branch_taken with target 0x20 while pc=5 -> one bubble (instr_valid=0), then instr=mem[0x20], instr_pc=0x20; same with stall=1 simultaneously gives identical result.
- Wrap: branch to 0x3F (D=6), no stall -> instr_pc=0x3F then instr_pc=0x00.
- Halt: mem[4]=0xFFFFFFFF -> instr=0xFFFFFFFF valid 1, halted=1, then bubbles forever with imem_address=4; stall during HALT keeps 0xFFFFFFFF visible.
- Halt squash: in HALT, branch_taken target 0x10 -> bubble, halted=0, then instr=mem[0x10] valid 1.
